// File: rtl/alu_pkg.sv
// alu_pkg
// Shared definitions for the 2-bit logic-unit datapath: operand and opcode
// widths, the last opcode of a sweep, and the sequencer state encoding.
package alu_pkg;

    localparam int WIDTH = 2;
    localparam int SEL_W = 3;

    localparam logic [SEL_W-1:0] SEL_LAST = 3'b111;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        EMIT  = 2'd2
    } state_t;

endpackage

// File: rtl/logic_op_sequencer.sv
// logic_op_sequencer
// Command/result sequencer wrapped around the combinational 2-bit logic unit.
// A command (operands plus opcode, or a sweep of every opcode) is accepted
// over cmd_valid/cmd_ready. The operands and opcode are driven onto lu_* for
// one full cycle, lu_out is captured at the end of that cycle, and the result
// is returned with its opcode over res_valid/res_ready.
//
// Ports
//   clk, rst_n                      clock, async active-low reset
//   cmd_valid/cmd_ready             command handshake
//   cmd_a, cmd_b, cmd_sel, cmd_sweep command payload
//   lu_a, lu_b, lu_sel              drive the logic unit inputs
//   lu_out                          logic unit output
//   res_valid/res_ready             result handshake
//   res_data, res_sel, res_last     result payload
//   busy                            command in progress
//
// State | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for a command, cmd_ready high, lu_* hold last values
// DRIVE | lu_* stable for one full cycle; lu_out captured at closing edge
// EMIT  | result presented; held until res_ready, then next opcode or IDLE
module logic_op_sequencer
    import alu_pkg::*;
#(
    parameter int WIDTH = alu_pkg::WIDTH,
    parameter int SEL_W = alu_pkg::SEL_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [WIDTH-1:0] cmd_a,
    input  logic [WIDTH-1:0] cmd_b,
    input  logic [SEL_W-1:0] cmd_sel,
    input  logic             cmd_sweep,
    output logic [WIDTH-1:0] lu_a,
    output logic [WIDTH-1:0] lu_b,
    output logic [SEL_W-1:0] lu_sel,
    input  logic [WIDTH-1:0] lu_out,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] res_data,
    output logic [SEL_W-1:0] res_sel,
    output logic             res_last,
    output logic             busy
);

    state_t state_q;
    state_t state_d;
    logic   sweep_q;
    logic   cmd_fire;
    logic   res_fire;
    logic   sel_at_last;

    assign cmd_fire    = cmd_valid && cmd_ready;
    assign res_fire    = res_valid && res_ready;
    // All-ones opcode is the final one of a sweep; equals SEL_LAST at SEL_W=3.
    assign sel_at_last = (lu_sel == {SEL_W{1'b1}});

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (cmd_fire) begin
                    state_d = DRIVE;
                end
            end
            DRIVE: begin
                state_d = EMIT;
            end
            EMIT: begin
                if (res_fire) begin
                    state_d = res_last ? IDLE : DRIVE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State-decoded outputs; both come straight from the state register so
    // cmd_ready never depends on res_ready.
    always_comb begin
        cmd_ready = 1'b0;
        busy      = 1'b1;
        if (state_q == IDLE) begin
            cmd_ready = 1'b1;
            busy      = 1'b0;
        end
    end

    // Datapath: logic-unit drive and result capture
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lu_a      <= '0;
            lu_b      <= '0;
            lu_sel    <= '0;
            sweep_q   <= 1'b0;
            res_valid <= 1'b0;
            res_data  <= '0;
            res_sel   <= '0;
            res_last  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (cmd_fire) begin
                        lu_a    <= cmd_a;
                        lu_b    <= cmd_b;
                        lu_sel  <= cmd_sweep ? '0 : cmd_sel;
                        sweep_q <= cmd_sweep;
                    end
                end
                DRIVE: begin
                    // lu_out is taken verbatim, X/Z included.
                    res_data  <= lu_out;
                    res_sel   <= lu_sel;
                    res_last  <= !sweep_q || sel_at_last;
                    res_valid <= 1'b1;
                end
                EMIT: begin
                    if (res_fire) begin
                        res_valid <= 1'b0;
                        // res_last covers opcode 7, so lu_sel never wraps.
                        if (!res_last) begin
                            lu_sel <= lu_sel + SEL_W'(1);
                        end
                    end
                end
                default: begin
                    res_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_logic_op_sequencer.sv
module tb_logic_op_sequencer;

    localparam int W = 2;
    localparam int S = 3;

    typedef struct packed {
        logic [W-1:0] data;
        logic [S-1:0] sel;
        logic         last;
    } exp_t;

    logic         clk;
    logic         rst_n;
    logic         cmd_valid;
    logic         cmd_ready;
    logic [W-1:0] cmd_a;
    logic [W-1:0] cmd_b;
    logic [S-1:0] cmd_sel;
    logic         cmd_sweep;
    logic [W-1:0] lu_a;
    logic [W-1:0] lu_b;
    logic [S-1:0] lu_sel;
    logic [W-1:0] lu_out;
    logic         res_valid;
    logic         res_ready;
    logic [W-1:0] res_data;
    logic [S-1:0] res_sel;
    logic         res_last;
    logic         busy;

    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;
    int   last_hs_cyc = 0;
    int   accept_cyc  = 0;
    exp_t sb_q[$];

    logic_op_sequencer dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_a     (cmd_a),
        .cmd_b     (cmd_b),
        .cmd_sel   (cmd_sel),
        .cmd_sweep (cmd_sweep),
        .lu_a      (lu_a),
        .lu_b      (lu_b),
        .lu_sel    (lu_sel),
        .lu_out    (lu_out),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_data  (res_data),
        .res_sel   (res_sel),
        .res_last  (res_last),
        .busy      (busy)
    );

    // Logic-unit stub
    assign lu_out = lu_sel[1:0] ^ lu_a;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc = cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Scoreboard monitor: compares each result at its handshake.
    always @(negedge clk) begin
        if (rst_n && res_valid && res_ready) begin
            if (sb_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_result: got sel %0d data %0h, expected none", res_sel, res_data);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                check("res_data", 32'(res_data), 32'(e.data));
                check("res_sel",  32'(res_sel),  32'(e.sel));
                check("res_last", 32'(res_last), 32'(e.last));
                if (res_last) last_hs_cyc = cyc;
            end
        end
    end

    task automatic push_cmd(input logic [W-1:0] a, input logic sweep, input logic [S-1:0] sel);
        exp_t e;
        if (sweep) begin
            for (int i = 0; i < 8; i++) begin
                e.sel  = S'(i);
                e.data = e.sel[1:0] ^ a;
                e.last = (i == 7);
                sb_q.push_back(e);
            end
        end else begin
            e.sel  = sel;
            e.data = sel[1:0] ^ a;
            e.last = 1'b1;
            sb_q.push_back(e);
        end
    endtask

    // Presents a command at a negedge and returns right after it is accepted.
    task automatic send_cmd(input logic [W-1:0] a, input logic [W-1:0] b,
                            input logic [S-1:0] sel, input logic sweep);
        bit ok;
        push_cmd(a, sweep, sel);
        @(negedge clk);
        cmd_a = a; cmd_b = b; cmd_sel = sel; cmd_sweep = sweep; cmd_valid = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (cmd_ready) begin ok = 1'b1; accept_cyc = cyc; break; end
            @(negedge clk);
        end
        if (!ok) check("accept_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1 cmd_valid = 1'b0;
    endtask

    task automatic wait_idle();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (!busy && sb_q.size() == 0) begin ok = 1'b1; break; end
        end
        check("idle_timeout", 32'(ok), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit ok;
        rst_n = 1'b0; cmd_valid = 1'b0; cmd_a = '0; cmd_b = '0;
        cmd_sel = '0; cmd_sweep = 1'b0; res_ready = 1'b0;

        // Reset values
        repeat (2) @(negedge clk);
        check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        check("rst_busy",      32'(busy),      32'd0);
        check("rst_res_valid", 32'(res_valid), 32'd0);
        check("rst_lu_a",      32'(lu_a),      32'd0);
        check("rst_lu_b",      32'(lu_b),      32'd0);
        check("rst_lu_sel",    32'(lu_sel),    32'd0);
        check("rst_res_data",  32'(res_data),  32'd0);
        check("rst_res_sel",   32'(res_sel),   32'd0);
        check("rst_res_last",  32'(res_last),  32'd0);
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("idle_cmd_ready", 32'(cmd_ready), 32'd1);
            check("idle_busy",      32'(busy),      32'd0);
            check("idle_res_valid", 32'(res_valid), 32'd0);
            check("idle_lu_sel",    32'(lu_sel),    32'd0);
        end

        // Single op: 2'b10 ^ 2'b01 = 2'b11
        res_ready = 1'b1;
        push_cmd(2'b10, 1'b0, 3'b101);
        cmd_a = 2'b10; cmd_b = 2'b01; cmd_sel = 3'b101; cmd_sweep = 1'b0; cmd_valid = 1'b1;
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        check("single_busy",      32'(busy),      32'd1);
        check("single_lu_a",      32'(lu_a),      32'd2);
        check("single_lu_b",      32'(lu_b),      32'd1);
        check("single_lu_sel",    32'(lu_sel),    32'd5);
        check("single_valid_t0",  32'(res_valid), 32'd0);
        @(posedge clk);
        #1 check("single_valid_t1", 32'(res_valid), 32'd1);
        @(posedge clk);
        #1 check("single_ready_back", 32'(cmd_ready), 32'd1);
        check("single_valid_drop", 32'(res_valid), 32'd0);
        check("single_lu_hold",    32'(lu_sel),    32'd5);
        wait_idle();

        // Sweep: data = sel ^ 0
        send_cmd(2'b00, 2'b00, 3'b000, 1'b1);
        wait_idle();
        check("sweep_cycles", 32'(last_hs_cyc - accept_cyc), 32'd16);

        // Back-pressure at sel=2 (a=01 -> data 11)
        send_cmd(2'b01, 2'b11, 3'b000, 1'b1);
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (busy && !res_valid && lu_sel == 3'd2) begin ok = 1'b1; break; end
        end
        check("bp_reach_sel2", 32'(ok), 32'd1);
        res_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("bp_res_valid", 32'(res_valid), 32'd1);
            check("bp_res_sel",   32'(res_sel),   32'd2);
            check("bp_res_data",  32'(res_data),  32'd3);
            check("bp_lu_sel",    32'(lu_sel),    32'd2);
        end
        res_ready = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1 check("bp_resume_sel3", 32'(lu_sel), 32'd3);
        wait_idle();

        // Command while busy: held until one IDLE cycle after res_last handshake
        send_cmd(2'b10, 2'b00, 3'b000, 1'b1);
        push_cmd(2'b11, 1'b0, 3'b001);
        @(negedge clk);
        cmd_a = 2'b11; cmd_b = 2'b00; cmd_sel = 3'b001; cmd_sweep = 1'b0; cmd_valid = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 60; i++) begin
            if (cmd_ready) begin ok = 1'b1; accept_cyc = cyc; break; end
            if (busy && lu_sel == 3'd4 && !res_valid)
                check("busy_cmd_ready", 32'(cmd_ready), 32'd0);
            @(negedge clk);
        end
        check("busy_accept_seen", 32'(ok), 32'd1);
        check("busy_accept_gap", 32'(accept_cyc - last_hs_cyc), 32'd1);
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        check("busy_new_lu_sel", 32'(lu_sel), 32'd1);
        wait_idle();

        // Reset mid-sweep at sel=4 in EMIT
        send_cmd(2'b10, 2'b01, 3'b000, 1'b1);
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (res_valid && res_sel == 3'd4) begin ok = 1'b1; break; end
        end
        check("mid_reach_sel4", 32'(ok), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        sb_q.delete();
        check("mid_cmd_ready", 32'(cmd_ready), 32'd1);
        check("mid_busy",      32'(busy),      32'd0);
        check("mid_res_valid", 32'(res_valid), 32'd0);
        check("mid_lu_a",      32'(lu_a),      32'd0);
        check("mid_lu_sel",    32'(lu_sel),    32'd0);
        check("mid_res_data",  32'(res_data),  32'd0);
        check("mid_res_sel",   32'(res_sel),   32'd0);
        check("mid_res_last",  32'(res_last),  32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("post_rst_valid", 32'(res_valid), 32'd0);
        end
        // Fresh command after reset: 2'b10 ^ 2'b01 = 2'b11
        send_cmd(2'b01, 2'b00, 3'b010, 1'b0);
        wait_idle();
        check("sb_empty", 32'(sb_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/logic_op_sequencer.md
# logic_op_sequencer

- Command/result sequencer that sits directly upstream and downstream of the 2-bit logic unit.
- Accepts an operand pair plus opcode, or a sweep request, over a valid/ready handshake.
- Drives the logic unit's a/b/sel inputs, registers its combinational output one cycle later, and returns each result with its opcode over a valid/ready result channel.
- Replaces hand-stepped sel stimulus with a clocked, back-pressure-aware engine in the ALU datapath.

## Interface
- WIDTH, 2, operand/result width
- SEL_W, 3, opcode width

- clk  in  1  clock, rising edge
- rst_n  in  1  reset, asynchronous assert, active-low
- cmd_valid  in  1  command present
- cmd_ready  out  1  block can accept command
- cmd_a  in  WIDTH  operand A
- cmd_b  in  WIDTH  operand B
- cmd_sel  in  SEL_W  opcode (single mode only)
- cmd_sweep  in  1  1 = run opcodes 0..7 in order; 0 = run cmd_sel once
- lu_a  out  WIDTH  to logic unit a_in
- lu_b  out  WIDTH  to logic unit b_in
- lu_sel  out  SEL_W  to logic unit sel
- lu_out  in  WIDTH  from logic unit out
- res_valid  out  1  result present
- res_ready  in  1  consumer accepts result
- res_data  out  WIDTH  captured lu_out
- res_sel  out  SEL_W  opcode that produced res_data
- res_last  out  1  final result of current command
- busy  out  1  state != IDLE

## Operation
- States: IDLE, DRIVE, EMIT.
- IDLE:
  - cmd_ready=1.
  - On cmd_valid & cmd_ready: latch cmd_a/cmd_b into lu_a/lu_b, and lu_sel <= cmd_sweep ? 0 : cmd_sel.
  - Latch the sweep flag; go to DRIVE.
- DRIVE: lu_* stable for one full cycle. At the closing edge:
  - res_data <= lu_out, res_sel <= lu_sel.
  - res_last <= (!sweep) | (lu_sel == 3'b111).
  - res_valid <= 1; go to EMIT.
- EMIT: hold res_* stable while res_valid & !res_ready. On res_valid & res_ready:
  - res_valid <= 0.
  - If res_last: go to IDLE.
  - Else: lu_sel <= lu_sel + 1, go to DRIVE.
- Sweep terminates at opcode 7; lu_sel never wraps to 0 within a command.
- lu_a/lu_b/lu_sel hold their last values in IDLE; they are not cleared after a command.
- lu_out is captured verbatim, including X/Z; no checking.
- cmd_* inputs are ignored outside IDLE, since cmd_ready=0.

## Timing
- Reset values:
  - state=IDLE, cmd_ready=1, busy=0.
  - lu_a=0, lu_b=0, lu_sel=0.
  - res_valid=0, res_data=0, res_sel=0, res_last=0.
- Reset mid-command: outputs go to reset values immediately; pending results are discarded; no res_last is emitted.
- Latency: command accepted at edge t0 -> res_valid=1 after edge t1 = t0+1 cycle.
- Per opcode, minimum 2 cycles (DRIVE + EMIT) with res_ready held high.
  - Sweep: 16 cycles from accept to last handshake.
  - Single: 2 cycles, then 1 cycle in IDLE before the next accept.
- res_ready may be high before res_valid; handshake completes in the first EMIT cycle.
- cmd_ready is a registered function of state; it does not combinationally depend on res_ready.
- No same-cycle transition from the final handshake to a new command accept.

## Structure
- Shared package alu_pkg:
  - WIDTH=2, SEL_W=3, SEL_LAST=3'b111.
  - State enum {IDLE, DRIVE, EMIT}.
- Single flat module; no sub-module.
- Logic unit instantiation and the wiring lu_* <-> a_in/b_in/sel/out happen at the parent level, not inside this block.

## Test plan
Bench stub for all scenarios: lu_out = lu_sel[1:0] ^ lu_a.

- Reset, then idle: after rst_n rises, cmd_ready=1, busy=0, res_valid=0, lu_sel=0 for 5 cycles.
- Single op: a=2'b10, b=2'b01, sel=3'b101, sweep=0, res_ready=1.
  - res_valid is high one cycle after accept.
  - res_data=2'b11, res_sel=5, res_last=1.
  - cmd_ready returns after the handshake.
- Sweep: a=2'b00, b=2'b00, sweep=1, res_ready=1.
  - Eight results with res_sel 0..7 and res_data 0,1,2,3,0,1,2,3.
  - res_last only on sel=7.
  - 16 cycles from accept to last handshake.
- Back-pressure: sweep with res_ready low for 3 cycles at sel=2.
  - res_data/res_sel/res_valid stay stable.
  - lu_sel stays at 2.
  - Resumes at sel=3 after the handshake.
- Command while busy: assert cmd_valid with a new sel=3'b001 during a sweep.
  - cmd_ready=0 throughout; the command is not taken.
  - Accepted only after res_last handshake plus one IDLE cycle.
- Reset mid-sweep: pull rst_n low at sel=4 in EMIT.
  - All outputs reach reset values immediately.
  - No further res_valid until a new command is accepted.
